// File: rtl/systolic_pkg.sv
// systolic_pkg
// Shared constants for the systolic array slice: default array dimension and
// operand width, the feeder state encoding, and the lane-packing helper used
// to locate lane i inside a packed N*W operand bus.
package systolic_pkg;

  localparam int DEFAULT_N = 4;
  localparam int DEFAULT_W = 8;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOADED = 3'd1;
  localparam logic [STATE_W-1:0] ST_CLEAR  = 3'd2;
  localparam logic [STATE_W-1:0] ST_STREAM = 3'd3;
  localparam logic [STATE_W-1:0] ST_FLUSH  = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE   = 3'd5;

  // Least-significant bit of lane 'lane' in a bus of 'w'-bit lanes.
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/systolic_feeder_buf.sv
// systolic_feeder_buf
// Operand storage for the feeder: 2*N*N entries of W bits. Entries 0..N*N-1
// hold A row-major, entries N*N..2*N*N-1 hold B row-major.
// Ports:
//   clk      - clock, write on rising edge
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - 2*N combinational read taps (taps 0..N-1 feed A rows,
//              taps N..2N-1 feed B columns)
//   rd_data  - data for each read tap
// Contents are deliberately not reset; a full load always precedes a stream.
module systolic_feeder_buf
  import systolic_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int W  = DEFAULT_W,
  parameter int AW = $clog2(2 * N * N)
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [W-1:0]               wr_data,
  input  logic [2*N-1:0][AW-1:0]     rd_addr,
  output logic [2*N-1:0][W-1:0]      rd_data
);

  localparam int DEPTH = 2 * N * N;

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < 2 * N; p++) begin
      rd_data[p] = mem[rd_addr[p]];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder
// Loads an N x N matrix A and an N x N matrix B element by element, then on
// start streams them into an N x N systolic array with the diagonal skew the
// array needs: row i of A is delayed by i cycles, column j of B by j cycles.
// Sequence after start: CLEAR (1 cycle, accumulator clear), STREAM (2N-1
// cycles), FLUSH (N cycles of zeros), DONE (1-cycle done pulse), back to IDLE.
// Ports:
//   clk      - clock
//   rst      - asynchronous active-low reset
//   in_valid - load element present on in_data
//   in_ready - feeder accepts a load element (IDLE only)
//   in_data  - load element, A row-major then B row-major
//   start    - begin streaming (honoured only once fully loaded)
//   a_row    - lane i drives array row i
//   b_col    - lane j drives array column j
//   pe_clr   - one-cycle accumulator clear
//   busy     - high during CLEAR, STREAM and FLUSH
//   done     - one-cycle pulse once results have settled
// All outputs are registered: they are computed from the next state and
// captured on the same edge that moves the FSM.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic           start,
  output logic [N*W-1:0] a_row,
  output logic [N*W-1:0] b_col,
  output logic           pe_clr,
  output logic           busy,
  output logic           done
);

  localparam int DEPTH = 2 * N * N;
  localparam int AW    = $clog2(DEPTH);
  localparam int TW    = $clog2(2 * N);

  logic [STATE_W-1:0]        state;
  logic [STATE_W-1:0]        state_nxt;
  logic [AW-1:0]             k;
  logic [TW-1:0]             t;
  logic [TW-1:0]             t_nxt;
  logic                      load_fire;
  logic [2*N-1:0][AW-1:0]    rd_addr;
  logic [2*N-1:0][W-1:0]     rd_data;
  logic [N*W-1:0]            a_row_nxt;
  logic [N*W-1:0]            b_col_nxt;

  // in_ready is high exactly in IDLE, so it doubles as the load gate.
  assign load_fire = in_valid && in_ready;

  systolic_feeder_buf #(
    .N  (N),
    .W  (W),
    .AW (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (load_fire),
    .wr_addr (k),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Next-state logic. t counts stream cycles in STREAM and is reused as the
  // flush-cycle counter in FLUSH.
  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    case (state)
      ST_IDLE: begin
        if (load_fire && k == AW'(DEPTH - 1)) begin
          state_nxt = ST_LOADED;
        end
      end
      ST_LOADED: begin
        if (start) begin
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_nxt = ST_STREAM;
        t_nxt     = '0;
      end
      ST_STREAM: begin
        if (t == TW'(2 * N - 2)) begin
          state_nxt = ST_FLUSH;
          t_nxt     = '0;
        end else begin
          t_nxt = t + TW'(1);
        end
      end
      ST_FLUSH: begin
        if (t == TW'(N - 1)) begin
          state_nxt = ST_DONE;
          t_nxt     = '0;
        end else begin
          t_nxt = t + TW'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        t_nxt     = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        t_nxt     = '0;
      end
    endcase
  end

  // Skewed read addresses for the upcoming stream cycle: row i of A reads
  // column t-i, column j of B reads row t-j. Out-of-window lanes keep
  // address 0 and are zeroed when the lanes are assembled.
  always_comb begin : addr_map
    int d;
    d       = 0;
    rd_addr = '0;
    for (int i = 0; i < N; i++) begin
      d = int'(t_nxt) - i;
      if (d >= 0 && d < N) begin
        rd_addr[i]     = AW'(i * N + d);
        rd_addr[N + i] = AW'(N * N + d * N + i);
      end
    end
  end

  // Lane assembly: only STREAM cycles carry operands, and only lanes whose
  // skewed index falls inside the matrix.
  always_comb begin : lane_pack
    int d;
    d         = 0;
    a_row_nxt = '0;
    b_col_nxt = '0;
    if (state_nxt == ST_STREAM) begin
      for (int i = 0; i < N; i++) begin
        d = int'(t_nxt) - i;
        if (d >= 0 && d < N) begin
          a_row_nxt[lane_lsb(i, W) +: W] = rd_data[i];
          b_col_nxt[lane_lsb(i, W) +: W] = rd_data[N + i];
        end
      end
    end
  end

  // State, counters and registered outputs. k returns to 0 both after the
  // final load element and when a run completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      k        <= '0;
      t        <= '0;
      in_ready <= 1'b1;
      a_row    <= '0;
      b_col    <= '0;
      pe_clr   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
      if (state == ST_DONE) begin
        k <= '0;
      end else if (load_fire) begin
        k <= (k == AW'(DEPTH - 1)) ? '0 : k + AW'(1);
      end
      in_ready <= (state_nxt == ST_IDLE);
      pe_clr   <= (state_nxt == ST_CLEAR);
      busy     <= (state_nxt == ST_CLEAR) || (state_nxt == ST_STREAM) ||
                  (state_nxt == ST_FLUSH);
      done     <= (state_nxt == ST_DONE);
      a_row    <= a_row_nxt;
      b_col    <= b_col_nxt;
    end
  end

endmodule
